// File: rtl/poly_out_streamer.sv
// Unload stage of the 8-bank NTT multiplier: reads all N coefficients in logical
// order through the conflict-free bank map and streams them out with backpressure.
module poly_out_streamer #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 7,
  parameter int IDX_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    rd_en,
  output logic [2:0]              rd_bank,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [8*DATA_WIDTH-1:0] q_all,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = {IDX_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_WIDTH-1:0]    r_idx;
  logic [IDX_WIDTH-1:0]    w_idx_next;
  logic                    r_rd_en;
  logic                    w_rd_en_next;
  logic [2:0]              r_rd_bank;
  logic [2:0]              w_rd_bank_next;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [ADDR_WIDTH-1:0]   w_rd_addr_next;
  logic                    r_rd_last;
  logic                    w_rd_last_next;

  logic                    r_pend_vld;
  logic [2:0]              r_pend_bank;
  logic                    r_pend_last;

  logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;

  logic [DATA_WIDTH-1:0]   w_slice [8];
  logic [DATA_WIDTH-1:0]   w_q_sel;
  logic [DATA_WIDTH:0]     w_head;
  logic                    w_head_last;
  logic                    w_push;
  logic                    w_pop;
  logic [SUM_W-1:0]        w_credit_used;
  logic                    w_issue;
  logic [2:0]              w_map_bank;
  logic [ADDR_WIDTH-1:0]   w_map_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      assign w_slice[gi] = q_all[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  // Map is fixed to the 1024-point layout shared with the core memory.
  assign w_map_bank = r_idx[2:0] + r_idx[5:3] + r_idx[8:6] + {2'b00, r_idx[9]};
  assign w_map_addr = r_idx[IDX_WIDTH-1:3];

  // Outstanding work is everything not yet popped: the read on the bank port,
  // the read whose data is on q_all, and the FIFO contents.
  assign w_credit_used = SUM_W'(r_count) + SUM_W'(r_rd_en) + SUM_W'(r_pend_vld);
  assign w_issue       = (r_state == S_READ) && (w_credit_used < SUM_W'(FIFO_DEPTH));

  assign w_q_sel     = w_slice[r_pend_bank];
  assign w_push      = r_pend_vld;
  assign w_head      = r_mem[r_rptr];
  assign w_head_last = w_head[DATA_WIDTH];
  assign m_valid     = (r_count != '0);
  assign w_pop       = m_valid && m_ready;
  assign m_data      = m_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_last      = m_valid && w_head_last;

  assign rd_en   = r_rd_en;
  assign rd_bank = r_rd_bank;
  assign rd_addr = r_rd_addr;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_bank <= '0;
      r_rd_addr <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_rd_en   <= w_rd_en_next;
      r_rd_bank <= w_rd_bank_next;
      r_rd_addr <= w_rd_addr_next;
      r_rd_last <= w_rd_last_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_rd_en_next   = 1'b0;
    w_rd_bank_next = r_rd_bank;
    w_rd_addr_next = r_rd_addr;
    w_rd_last_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_READ;
          w_idx_next   = '0;
        end
      end
      S_READ: begin
        if (w_issue) begin
          w_rd_en_next   = 1'b1;
          w_rd_bank_next = w_map_bank;
          w_rd_addr_next = w_map_addr;
          w_rd_last_next = (r_idx == LAST_IDX);
          w_idx_next     = r_idx + IDX_WIDTH'(1);
          if (r_idx == LAST_IDX) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // One-deep delay matching the bank read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_bank <= '0;
      r_pend_last <= 1'b0;
    end else begin
      r_pend_vld  <= r_rd_en;
      r_pend_bank <= r_rd_bank;
      r_pend_last <= r_rd_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_pend_last, w_q_sel};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_poly_out_streamer.sv
// Directed bench: bank model preloaded with logical index values, checks order,
// timing, bank mapping, credit limit, stall stability, ignored start and reset.
module tb_poly_out_streamer;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rd_en;
  logic [2:0]    rd_bank;
  logic [6:0]    rd_addr;
  logic [111:0]  q_all;
  logic [13:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [13:0] bmem  [8][128];
  logic [13:0] q_reg [8];

  int map_bank_exp [16] = '{0,1,2,3,4,5,6,7,1,2,3,4,5,6,7,0};

  int rel, exp_idx, beats, dones, first_valid, last_cyc, done_cyc;
  int issued, accepted, stall_reads, map_k;
  logic stall_prev;
  logic [13:0] held_data;
  logic held_last;

  always #5 clk = ~clk;

  poly_out_streamer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .q_all   (q_all),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_q
      assign q_all[14*gi +: 14] = q_reg[gi];
    end
  endgenerate

  always @(posedge clk) begin
    if (rd_en) begin
      for (int b = 0; b < 8; b++) q_reg[b] <= bmem[b][rd_addr];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"},   rd_en,   0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"},  m_data,  0);
    chk({tag, "_m_last"},  m_last,  0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_done"},    done,    0);
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready=0 for the first 20 cycles
  task automatic run_transfer(input string name, input int mode, input int extra_start,
                              input int rst_at);
    bit hit_rst = 1'b0;
    exp_idx = 0; beats = 0; dones = 0; first_valid = -1; last_cyc = -1; done_cyc = -1;
    issued = 0; accepted = 0; stall_reads = 0; map_k = 0; stall_prev = 1'b0;
    @(negedge clk);
    chk({name, "_idle_busy"}, busy, 0);
    start = 1'b1;
    rel = -1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rel = rel + 1;
      start = (rel == extra_start);
      if (rst_at >= 0 && rel == rst_at) begin
        rst = 1'b0;
        #1;
        chk_outputs_zero({name, "_async"});
        hit_rst = 1'b1;
        break;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (rel >= 20);
      endcase
      if (rel == 0) chk({name, "_busy_c0"}, busy, 1);
      if (rd_en) begin
        issued++;
        chk({name, "_credit"}, int'(issued - accepted <= 4), 1);
        if (map_k < 16) begin
          chk({name, "_map_bank"}, rd_bank, map_bank_exp[map_k]);
          chk({name, "_map_addr"}, rd_addr, map_k / 8);
          map_k++;
        end
        if (mode == 2 && rel < 20) stall_reads++;
      end
      if (mode == 2 && rel == 20) begin
        chk({name, "_stall_reads"}, stall_reads, 4);
        chk({name, "_stall_rd_en"}, rd_en, 0);
      end
      if (stall_prev) begin
        chk({name, "_hold_valid"}, m_valid, 1);
        chk({name, "_hold_data"},  m_data,  held_data);
        chk({name, "_hold_last"},  m_last,  held_last);
      end
      if (m_valid && first_valid < 0) first_valid = rel;
      if (m_valid && m_ready) begin
        chk({name, "_data"}, m_data, exp_idx);
        chk({name, "_last"}, m_last, int'(exp_idx == 1023));
        if (m_last) last_cyc = rel;
        exp_idx++;
        beats++;
        accepted++;
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
      if (done) begin
        dones++;
        chk({name, "_busy_done"}, busy, 1);
        if (done_cyc < 0) done_cyc = rel;
      end
      if (done_cyc >= 0 && rel >= done_cyc + 3) break;
    end
    start = 1'b0;
    if (!hit_rst) begin
      chk({name, "_timeout"}, int'(done_cyc >= 0), 1);
      chk({name, "_beats"}, beats, 1024);
      chk({name, "_dones"}, dones, 1);
      chk({name, "_done_after_last"}, done_cyc, last_cyc + 1);
      chk({name, "_busy_after"}, busy, 0);
      if (mode == 0) begin
        chk({name, "_first_valid"}, first_valid, 3);
        chk({name, "_last_cyc"}, last_cyc, 1026);
        chk({name, "_done_cyc"}, done_cyc, 1027);
      end
    end
    $display("xfer %s beats=%0d dones=%0d first_valid=%0d last_cyc=%0d done_cyc=%0d",
             name, beats, dones, first_valid, last_cyc, done_cyc);
  endtask

  initial begin
    logic [9:0] iv;
    int b;
    for (int i = 0; i < 1024; i++) begin
      iv = 10'(i);
      b = (int'(iv[2:0]) + int'(iv[5:3]) + int'(iv[8:6]) + int'(iv[9])) % 8;
      bmem[b][iv[9:3]] = 14'(i);
    end
    for (int k = 0; k < 8; k++) q_reg[k] = '0;

    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    run_transfer("full", 0, -1, -1);
    run_transfer("random", 1, -1, -1);
    run_transfer("stall", 2, -1, -1);
    run_transfer("restart", 0, 500, -1);
    run_transfer("rst_mid", 0, -1, 300);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_done", done, 0);
      chk("rst_hold_valid", m_valid, 0);
    end
    rst = 1'b1;
    run_transfer("after_rst", 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
